// File: rtl/uart_tx_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter_pkg
//   Shared definitions for the UART transmit arbiter:
//   - state encoding of the arbiter FSM (3-bit, kept as plain constants so
//     legacy code and the bench can probe/compare state values directly)
//   - rr_next(): modular step used by the round-robin picker
// -----------------------------------------------------------------------------
package uart_tx_arbiter_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [STATE_W-1:0] ST_IDLE      = 3'd0;
   localparam logic [STATE_W-1:0] ST_SEND      = 3'd1;
   localparam logic [STATE_W-1:0] ST_WAIT_BUSY = 3'd2;
   localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd3;
   localparam logic [STATE_W-1:0] ST_RELEASE   = 3'd4;

   // Index reached by stepping k places past base in a ring of n entries.
   function automatic int unsigned rr_next(input int unsigned base,
                                           input int unsigned k,
                                           input int unsigned n);
      return (base + k) % n;
   endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker. Searches last+1, last+2, ... (mod
//   NUM_REQ) and returns the first requesting index.
// Ports
//   req     in   NUM_REQ   request vector (1 = source has data)
//   last    in   IDX_W     index of the previous owner
//   winner  out  IDX_W     chosen index (0 when valid=0)
//   valid   out  1         at least one request present
// -----------------------------------------------------------------------------
module rr_pick
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last,
   output logic [IDX_W-1:0]   winner,
   output logic               valid
);

   always_comb begin
      int unsigned idx;
      idx    = 0;
      winner = '0;
      valid  = 1'b0;
      // k runs 1..NUM_REQ so the previous owner is considered last.
      for (int unsigned k = 1; k <= NUM_REQ; k++) begin
         idx = rr_next(32'(last), k, NUM_REQ);
         if (!valid && req[IDX_W'(idx)]) begin
            valid  = 1'b1;
            winner = IDX_W'(idx);
         end
      end
   end

endmodule

// File: rtl/uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// uart_tx_arbiter
//   Shares one UART transmitter between NUM_REQ FIFO byte sources. A source is
//   chosen round-robin, up to BURST_MAX bytes are sent from it, then the
//   arbiter releases and re-arbitrates. A missing tx_busy response within
//   BUSY_TO cycles sets a sticky error and abandons the grant.
// Ports
//   clk          in   1                rising-edge clock
//   rst          in   1                asynchronous active-high reset
//   req_empty    in   NUM_REQ          per-source FIFO empty flag
//   req_data     in   NUM_REQ*DATA_W   per-source FIFO head, source i at [i*DATA_W +: DATA_W]
//   req_pop      out  NUM_REQ          one-cycle pop to the granted source
//   tx_data      out  DATA_W           byte to UART, held from tx_start until busy falls
//   tx_start     out  1                one-cycle start pulse to UART
//   tx_busy      in   1                UART transmitter busy
//   grant        out  NUM_REQ          one-hot current owner, 0 when idle
//   err_timeout  out  1                sticky busy-timeout flag, cleared by rst only
// -----------------------------------------------------------------------------
module uart_tx_arbiter
   import uart_tx_arbiter_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 2,
   parameter int unsigned DATA_W    = 8,
   parameter int unsigned BURST_MAX = 4,
   parameter int unsigned BUSY_TO   = 16
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_empty,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_pop,
   output logic [DATA_W-1:0]         tx_data,
   output logic                      tx_start,
   input  logic                      tx_busy,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      err_timeout
);

   localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int unsigned BC_W  = $clog2(BURST_MAX + 1);
   localparam int unsigned TO_W  = (BUSY_TO > 1) ? $clog2(BUSY_TO + 1) : 1;

   // burst_cnt + 1 < BURST_MAX  <=>  burst_cnt < BURST_MAX - 1
   localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_MAX - 1);
   localparam logic [TO_W-1:0] TO_LAST    = TO_W'(BUSY_TO - 1);

   logic [STATE_W-1:0] state;
   logic [IDX_W-1:0]   last;
   logic [IDX_W-1:0]   g_idx;
   logic [BC_W-1:0]    burst_cnt;
   logic [TO_W-1:0]    to_cnt;

   logic [IDX_W-1:0]   winner;
   logic               pick_valid;
   logic [DATA_W-1:0]  win_data;
   logic [DATA_W-1:0]  own_data;
   logic               own_empty;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req    (~req_empty),
      .last   (last),
      .winner (winner),
      .valid  (pick_valid)
   );

   // Head byte of the arbitration winner, and head/empty of the current owner.
   // Only the owner's FIFO is looked at while a grant is held.
   always_comb begin
      win_data  = '0;
      own_data  = '0;
      own_empty = 1'b1;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (winner == IDX_W'(i)) begin
            win_data = req_data[i*DATA_W +: DATA_W];
         end
         if (g_idx == IDX_W'(i)) begin
            own_data  = req_data[i*DATA_W +: DATA_W];
            own_empty = req_empty[i];
         end
      end
   end

   // Start and pop are pure decodes of SEND so they vanish the instant rst rises.
   assign tx_start = (state == ST_SEND);
   assign req_pop  = (state == ST_SEND) ? grant : '0;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         last        <= IDX_W'(NUM_REQ - 1);
         g_idx       <= '0;
         burst_cnt   <= '0;
         to_cnt      <= '0;
         grant       <= '0;
         tx_data     <= '0;
         err_timeout <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (pick_valid && !tx_busy) begin
                  grant     <= NUM_REQ'(1) << winner;
                  g_idx     <= winner;
                  tx_data   <= win_data;
                  burst_cnt <= '0;
                  state     <= ST_SEND;
               end
            end

            ST_SEND: begin
               to_cnt <= '0;
               state  <= ST_WAIT_BUSY;
            end

            ST_WAIT_BUSY: begin
               if (tx_busy) begin
                  state <= ST_WAIT_DONE;
               end else begin
                  to_cnt <= to_cnt + TO_W'(1);
                  if (to_cnt == TO_LAST) begin
                     err_timeout <= 1'b1;
                     state       <= ST_RELEASE;
                  end
               end
            end

            ST_WAIT_DONE: begin
               if (!tx_busy) begin
                  burst_cnt <= burst_cnt + BC_W'(1);
                  if (burst_cnt < BURST_LAST && !own_empty) begin
                     tx_data <= own_data;
                     state   <= ST_SEND;
                  end else begin
                     state <= ST_RELEASE;
                  end
               end
            end

            ST_RELEASE: begin
               last  <= g_idx;
               grant <= '0;
               state <= ST_IDLE;
            end

            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_arbiter
//   Bench for uart_tx_arbiter: queue-based FIFO sources, a behavioural UART,
//   and a round-robin/burst reference order computed from the loaded queues.
// -----------------------------------------------------------------------------
module tb_uart_tx_arbiter;

   localparam int unsigned NUM_REQ   = 2;
   localparam int unsigned DATA_W    = 8;
   localparam int unsigned BURST_MAX = 4;
   localparam int unsigned BUSY_TO   = 16;

   logic                      clk = 1'b0;
   logic                      rst = 1'b1;
   logic [NUM_REQ-1:0]        req_empty;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_pop;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_start;
   logic                      tx_busy;
   logic [NUM_REQ-1:0]        grant;
   logic                      err_timeout;

   logic uart_busy = 1'b0;
   logic hold_busy = 1'b0;
   assign tx_busy = uart_busy | hold_busy;

   int unsigned total = 0;
   int unsigned bad   = 0;
   int unsigned cyc   = 0;

   logic [7:0]  src_q[NUM_REQ][$];
   int          got[$];
   int          exp_q[$];
   int unsigned pops[NUM_REQ];
   int unsigned n_starts  = 0;
   int unsigned start_cyc = 0;
   bit          uart_dead = 1'b0;
   int unsigned busy_len  = 10;

   uart_tx_arbiter #(
      .NUM_REQ   (NUM_REQ),
      .DATA_W    (DATA_W),
      .BURST_MAX (BURST_MAX),
      .BUSY_TO   (BUSY_TO)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .req_empty   (req_empty),
      .req_data    (req_data),
      .req_pop     (req_pop),
      .tx_data     (tx_data),
      .tx_start    (tx_start),
      .tx_busy     (tx_busy),
      .grant       (grant),
      .err_timeout (err_timeout)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void refresh();
      for (int i = 0; i < NUM_REQ; i++) begin
         req_empty[i] = (src_q[i].size() == 0);
         req_data[i*DATA_W +: DATA_W] = (src_q[i].size() != 0) ? src_q[i][0] : '0;
      end
   endfunction

   function automatic int oh2idx(input logic [NUM_REQ-1:0] g);
      for (int i = 0; i < NUM_REQ; i++) if (g[i]) return i;
      return -1;
   endfunction

   // Reference order: round-robin from last=NUM_REQ-1, each owner drains up
   // to BURST_MAX bytes; valid when all bytes are loaded before the first grant.
   function automatic void build_exp();
      logic [7:0]  m[NUM_REQ][$];
      int unsigned lst;
      int unsigned s;
      int unsigned n;
      bit          found;
      for (int i = 0; i < NUM_REQ; i++) m[i] = src_q[i];
      exp_q = {};
      lst   = NUM_REQ - 1;
      found = 1'b1;
      while (found) begin
         found = 1'b0;
         for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            s = (lst + k) % NUM_REQ;
            if (m[s].size() != 0) begin
               found = 1'b1;
               n = 0;
               while (n < BURST_MAX && m[s].size() != 0) begin
                  exp_q.push_back(int'(s) * 256 + int'(m[s].pop_front()));
                  n++;
               end
               lst = s;
               break;
            end
         end
      end
   endfunction

   function automatic int seq_diff();
      int n;
      n = (got.size() < exp_q.size()) ? got.size() : exp_q.size();
      for (int i = 0; i < n; i++) if (got[i] != exp_q[i]) return i;
      if (got.size() != exp_q.size()) return n;
      return -1;
   endfunction

   function automatic int got_at(input int i);
      return (i >= 0 && i < got.size()) ? got[i] : -1;
   endfunction

   function automatic int exp_at(input int i);
      return (i >= 0 && i < exp_q.size()) ? exp_q[i] : -1;
   endfunction

   // FIFO sources: a pop seen in the SEND cycle removes the head.
   initial begin
      refresh();
      forever begin
         @(negedge clk);
         for (int i = 0; i < NUM_REQ; i++) begin
            if (req_pop[i] === 1'b1) begin
               total++;
               if (src_q[i].size() == 0) begin
                  bad++;
                  $display("FAIL pop_of_empty src=%0d: got pop, required no pop", i);
               end else begin
                  void'(src_q[i].pop_front());
               end
               pops[i]++;
            end
         end
         refresh();
      end
   end

   // UART model: busy rises the cycle after tx_start and lasts busy_len cycles.
   initial begin
      logic [DATA_W-1:0] b;
      bit                lost;
      forever begin
         @(negedge clk);
         if (tx_start === 1'b1) begin
            total++;
            if (tx_busy !== 1'b0 || req_pop !== grant || oh2idx(grant) < 0) begin
               bad++;
               $display("FAIL start_handshake: got busy=%b pop=%b grant=%b, required busy=0 pop=grant one-hot",
                        tx_busy, req_pop, grant);
            end
            n_starts++;
            start_cyc = cyc;
            b = tx_data;
            got.push_back(oh2idx(grant) * 256 + int'(b));
            if (!uart_dead) begin
               lost = 1'b0;
               @(posedge clk);
               #1 uart_busy = 1'b1;
               repeat (busy_len) begin
                  @(negedge clk);
                  if (rst) lost = 1'b1;
                  if (!lost) begin
                     total++;
                     if (tx_data !== b) begin
                        bad++;
                        $display("FAIL tx_data_stable: got %h required %h", tx_data, b);
                     end
                  end
               end
               @(posedge clk);
               #1 uart_busy = 1'b0;
            end
         end else if (req_pop !== '0) begin
            total++;
            bad++;
            $display("FAIL pop_without_start: got pop=%b, required 0", req_pop);
         end
      end
   end

   task automatic push(input int s, input logic [7:0] v);
      src_q[s].push_back(v);
      refresh();
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   // Runs until sources are empty and the arbiter is idle; returns grants seen.
   task automatic wait_drain(input int budget, output bit ok, output logic [NUM_REQ-1:0] seen);
      ok   = 1'b0;
      seen = '0;
      for (int c = 0; c < budget && !ok; c++) begin
         @(negedge clk);
         seen = seen | grant;
         ok = (grant == '0) && (tx_busy == 1'b0) &&
              (src_q[0].size() == 0) && (src_q[1].size() == 0);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      total++; if (req_pop !== '0)      begin bad++; $display("FAIL reset_req_pop: got %b required 0", req_pop); end
      total++; if (tx_start !== 1'b0)   begin bad++; $display("FAIL reset_tx_start: got %b required 0", tx_start); end
      total++; if (tx_data !== '0)      begin bad++; $display("FAIL reset_tx_data: got %h required 0", tx_data); end
      total++; if (grant !== '0)        begin bad++; $display("FAIL reset_grant: got %b required 0", grant); end
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL reset_err: got %b required 0", err_timeout); end
      rst = 1'b0;
   endtask

   task automatic test_single();
      bit ok; logic [NUM_REQ-1:0] seen; int d;
      busy_len = 10;
      got = {};
      pops[0] = 0; pops[1] = 0;
      @(posedge clk); #1;
      push(0, 8'h41);
      push(0, 8'h42);
      exp_q = {'h41, 'h42};
      wait_drain(500, ok, seen);
      total++; if (!ok) begin bad++; $display("FAIL single_drain: got timeout, required idle"); end
      d = seq_diff();
      total++; if (d != -1) begin bad++; $display("FAIL single_order idx=%0d: got %h required %h", d, got_at(d), exp_at(d)); end
      total++; if (pops[0] != 2 || pops[1] != 0) begin bad++; $display("FAIL single_pops: got %0d/%0d required 2/0", pops[0], pops[1]); end
      total++; if (seen !== 2'b01) begin bad++; $display("FAIL single_grant_seen: got %b required 01", seen); end
      total++; if (grant !== 2'b00) begin bad++; $display("FAIL single_grant_end: got %b required 00", grant); end
   endtask

   task automatic test_two_full();
      bit ok; logic [NUM_REQ-1:0] seen; int d;
      do_reset();
      got = {};
      for (int i = 0; i < 6; i++) begin
         push(0, 8'(8'h10 + i));
         push(1, 8'(8'h20 + i));
      end
      exp_q = {'h10, 'h11, 'h12, 'h13, 256+'h20, 256+'h21, 256+'h22, 256+'h23,
               'h14, 'h15, 256+'h24, 256+'h25};
      wait_drain(1000, ok, seen);
      total++; if (!ok) begin bad++; $display("FAIL two_full_drain: got timeout, required idle"); end
      d = seq_diff();
      total++; if (d != -1) begin bad++; $display("FAIL two_full_order idx=%0d: got %h required %h", d, got_at(d), exp_at(d)); end
   endtask

   task automatic test_mid_burst();
      int gap; int zeros; bit seen0; bit done; int d;
      do_reset();
      got = {};
      push(0, 8'hA0); push(0, 8'hA1);
      push(1, 8'hB0); push(1, 8'hB1); push(1, 8'hB2);
      build_exp();
      gap = -1; zeros = 0; seen0 = 1'b0; done = 1'b0;
      for (int c = 0; c < 800 && !done; c++) begin
         @(negedge clk);
         if (grant == 2'b01) seen0 = 1'b1;
         else if (seen0 && grant == 2'b00 && gap < 0) zeros++;
         else if (seen0 && grant == 2'b10 && gap < 0) gap = zeros;
         if (gap >= 0 && grant == '0 && !tx_busy && src_q[1].size() == 0) done = 1'b1;
      end
      total++; if (!done) begin bad++; $display("FAIL mid_burst_drain: got timeout, required idle"); end
      total++; if (gap != 1) begin bad++; $display("FAIL mid_burst_gap: got %0d idle cycles required 1", gap); end
      d = seq_diff();
      total++; if (d != -1) begin bad++; $display("FAIL mid_burst_order idx=%0d: got %h required %h", d, got_at(d), exp_at(d)); end
   endtask

   task automatic test_busy_held();
      bit ok; logic [NUM_REQ-1:0] seen; int d; int unsigned s0; int lat;
      got = {};
      @(posedge clk); #1;
      hold_busy = 1'b1;
      push(0, 8'h55);
      exp_q = {'h55};
      s0 = n_starts;
      repeat (20) @(negedge clk);
      total++; if (n_starts != s0) begin bad++; $display("FAIL busy_held_start: got %0d starts required 0", n_starts - s0); end
      @(posedge clk); #1 hold_busy = 1'b0;
      lat = -1;
      for (int c = 1; c <= 5 && lat < 0; c++) begin
         @(negedge clk);
         if (n_starts != s0) lat = c;
      end
      total++; if (lat < 1 || lat > 2) begin bad++; $display("FAIL busy_held_latency: got %0d required 1..2", lat); end
      wait_drain(300, ok, seen);
      d = seq_diff();
      total++; if (!ok || d != -1) begin bad++; $display("FAIL busy_held_order idx=%0d: got %h required %h", d, got_at(d), exp_at(d)); end
   endtask

   task automatic test_timeout();
      bit ok; logic [NUM_REQ-1:0] seen; int d; int unsigned s0; int diff; bit hit;
      uart_dead = 1'b1;
      got = {};
      @(posedge clk); #1;
      s0 = n_starts;
      push(0, 8'h66);
      for (int c = 0; c < 20 && n_starts == s0; c++) @(negedge clk);
      total++; if (err_timeout !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b required 0", err_timeout); end
      hit = 1'b0;
      for (int c = 0; c < 60 && !hit; c++) begin
         @(negedge clk);
         hit = (err_timeout === 1'b1);
      end
      diff = int'(cyc) - int'(start_cyc);
      total++;
      if (!hit || diff < int'(BUSY_TO) || diff > int'(BUSY_TO) + 2) begin
         bad++; $display("FAIL timeout_delay: got %0d cycles (hit=%0d) required %0d..%0d", diff, hit, BUSY_TO, BUSY_TO + 2);
      end
      for (int c = 0; c < 10 && grant != '0; c++) @(negedge clk);
      total++; if (grant !== '0) begin bad++; $display("FAIL timeout_release: got grant %b required 00", grant); end
      uart_dead = 1'b0;
      got = {};
      @(posedge clk); #1;
      push(1, 8'h77);
      exp_q = {256 + 'h77};
      wait_drain(300, ok, seen);
      d = seq_diff();
      total++; if (!ok || d != -1) begin bad++; $display("FAIL timeout_recover idx=%0d: got %h required %h", d, got_at(d), exp_at(d)); end
      total++; if (err_timeout !== 1'b1) begin bad++; $display("FAIL timeout_sticky: got %b required 1", err_timeout); end
   endtask

   task automatic test_reset_mid();
      bit ok; logic [NUM_REQ-1:0] seen; int d; bit hit;
      busy_len = 10;
      @(posedge clk); #1;
      push(1, 8'h88);
      hit = 1'b0;
      for (int c = 0; c < 50 && !hit; c++) begin
         @(negedge clk);
         hit = (grant == 2'b10) && (tx_busy == 1'b1);
      end
      total++; if (!hit) begin bad++; $display("FAIL reset_mid_setup: got no busy grant, required grant=10 busy=1"); end
      @(posedge clk); #3 rst = 1'b1;
      #1;
      total++;
      if (grant !== '0 || tx_data !== '0 || tx_start !== 1'b0 || req_pop !== '0 || err_timeout !== 1'b0) begin
         bad++; $display("FAIL reset_mid_outputs: got grant=%b data=%h start=%b pop=%b err=%b, required all 0",
                         grant, tx_data, tx_start, req_pop, err_timeout);
      end
      @(posedge clk); #1 rst = 1'b0;
      got = {};
      push(0, 8'h91);
      push(1, 8'h92);
      build_exp();
      wait_drain(500, ok, seen);
      d = seq_diff();
      total++; if (!ok || d != -1) begin bad++; $display("FAIL reset_mid_order idx=%0d: got %h required %h", d, got_at(d), exp_at(d)); end
   endtask

   task automatic test_random();
      bit ok; logic [NUM_REQ-1:0] seen; int d; int unsigned n;
      for (int r = 0; r < 6; r++) begin
         do_reset();
         busy_len = $urandom_range(1, 6);
         got = {};
         for (int s = 0; s < NUM_REQ; s++) begin
            n = $urandom_range(0, 7);
            for (int unsigned k = 0; k < n; k++) push(s, 8'($urandom_range(0, 255)));
         end
         build_exp();
         wait_drain(2000, ok, seen);
         total++; if (!ok) begin bad++; $display("FAIL random_drain round=%0d: got timeout, required idle", r); end
         d = seq_diff();
         total++; if (d != -1) begin bad++; $display("FAIL random_order round=%0d idx=%0d: got %h required %h", r, d, got_at(d), exp_at(d)); end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_two_full();
      test_mid_burst();
      test_busy_held();
      test_timeout();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
